// File: rtl/hps_ext_master.sv
// hps_ext_master: strobed external-bus master with 16-word write and read buffers.
// Define HPS_EXT_MASTER_POLL_EN to add the autonomous status poll and poll_done.
module hps_ext_master #(
    parameter int STROBE_GAP  = 2,
    parameter int CLOSE_GAP   = 2,
    parameter int POLL_PERIOD = 1000
) (
    input  logic        clk_sys,
    input  logic        reset,
    inout  wire  [35:0] EXT_BUS,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_cmd,
    input  logic [4:0]  req_len,
    input  logic        wr_we,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        done_ack
`ifdef HPS_EXT_MASTER_POLL_EN
    ,
    output logic        poll_done
`endif
);

    if (STROBE_GAP < 1 || STROBE_GAP > 15 ||
        CLOSE_GAP < 1 || CLOSE_GAP > 15 || POLL_PERIOD < 1) begin : g_param_check
        $error("hps_ext_master: parameter out of range");
    end

    localparam logic [3:0] SG_LAST = 4'(STROBE_GAP - 1);
    localparam logic [3:0] CG_LAST = 4'(CLOSE_GAP - 1);
    localparam logic [3:0] CG_PRE  = 4'(CLOSE_GAP - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_STROBE,
        S_GAP,
        S_CLOSE
    } state_t;

    state_t      state_q;
    logic [4:0]  k_q;
    logic [4:0]  len_q;
    logic [15:0] cmd_q;
    logic [3:0]  cnt_q;
    logic [15:0] din_q;
    logic        strobe_q;
    logic        enable_q;
    logic        busy_q;
    logic        done_q;
    logic        ack_q;

    logic [15:0] wbuf_q [16];
    logic [15:0] rbuf_q [16];

    logic [15:0] bus_dout;
    logic        bus_den;
    logic        gap_last;
    logic        cap_en;
    logic [3:0]  cap_idx;
    logic        fin;
    logic        go;
    logic [15:0] go_cmd;
    logic [4:0]  go_len;

    assign EXT_BUS[31:16] = din_q;
    assign EXT_BUS[33]    = strobe_q;
    assign EXT_BUS[34]    = enable_q;
    assign bus_dout       = EXT_BUS[15:0];
    assign bus_den        = EXT_BUS[32];

    assign req_ready = (state_q == S_IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_ack  = ack_q;
    assign rd_data   = rbuf_q[rd_addr];

    assign gap_last = (state_q == S_GAP) && (cnt_q == SG_LAST);
    assign cap_en   = gap_last && (k_q != 5'd0);
    assign cap_idx  = 4'(k_q - 5'd1);

    // With a one-cycle CLOSE the pulse must be armed on the way out of GAP.
    assign fin = (CLOSE_GAP == 1) ? (gap_last && !(k_q < len_q))
                                  : ((state_q == S_CLOSE) && (cnt_q == CG_PRE));

`ifdef HPS_EXT_MASTER_POLL_EN
    localparam int PW = $clog2(POLL_PERIOD + 1);

    logic [PW-1:0] poll_cnt_q;
    logic          poll_q;
    logic          poll_done_q;
    logic          poll_hit;
    logic          go_poll;

    assign poll_done = poll_done_q;
    assign poll_hit  = (poll_cnt_q == PW'(POLL_PERIOD - 1));

    always_ff @(posedge clk_sys) begin
        if (reset || state_q != S_IDLE || go) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
        end
    end
`endif

    // A user request always beats a poll trigger on the same cycle.
    always_comb begin
        go     = 1'b0;
        go_cmd = req_cmd;
        go_len = req_len;
`ifdef HPS_EXT_MASTER_POLL_EN
        go_poll = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            if (req_valid) begin
                go = 1'b1;
            end
`ifdef HPS_EXT_MASTER_POLL_EN
            else if (poll_hit) begin
                go      = 1'b1;
                go_cmd  = 16'h00F0;
                go_len  = 5'd7;
                go_poll = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_we) begin
            wbuf_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (cap_en) begin
            rbuf_q[cap_idx] <= bus_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            len_q    <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            strobe_q <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
`ifdef HPS_EXT_MASTER_POLL_EN
            poll_q      <= 1'b0;
            poll_done_q <= 1'b0;
`endif
        end else begin
`ifdef HPS_EXT_MASTER_POLL_EN
            done_q      <= fin && !poll_q;
            poll_done_q <= fin && poll_q;
`else
            done_q <= fin;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        cmd_q    <= go_cmd;
                        len_q    <= (go_len > 5'd16) ? 5'd16 : go_len;
                        k_q      <= '0;
                        enable_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_OPEN;
`ifdef HPS_EXT_MASTER_POLL_EN
                        poll_q   <= go_poll;
`endif
                    end
                end
                S_OPEN: begin
                    state_q  <= S_STROBE;
                    strobe_q <= 1'b1;
                    din_q    <= cmd_q;
                end
                S_STROBE: begin
                    state_q  <= S_GAP;
                    strobe_q <= 1'b0;
                    cnt_q    <= '0;
                end
                S_GAP: begin
                    if (cnt_q == SG_LAST) begin
                        if (k_q == 5'd0) begin
                            ack_q <= bus_den;
                        end
                        if (k_q < len_q) begin
                            state_q  <= S_STROBE;
                            strobe_q <= 1'b1;
                            din_q    <= wbuf_q[k_q[3:0]];
                            k_q      <= k_q + 5'd1;
                        end else begin
                            state_q  <= S_CLOSE;
                            enable_q <= 1'b0;
                            cnt_q    <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_CLOSE: begin
                    if (cnt_q == CG_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_ext_master.sv
// Scoreboard bench for hps_ext_master: stimulus pushes expected words and
// transaction records; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hps_ext_master;
    localparam int SG = 2;
    localparam int CG = 2;
    localparam int PP = 50;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    wire  [35:0] bus;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0;
    logic [4:0]  req_len = '0;
    logic        wr_we = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy, done, done_ack, pd;
    logic        resp_ack = 1'b1;
    logic [15:0] rsp_q = '0;
    logic        rst_at_edge = 1'b0;

    wire         io_strobe = bus[33];
    wire         io_enable = bus[34];
    wire  [15:0] io_din    = bus[31:16];

    assign bus[15:0] = rsp_q;
    assign bus[32]   = resp_ack;

`ifdef HPS_EXT_MASTER_POLL_EN
    logic poll_done;
    assign pd = poll_done;
`else
    assign pd = 1'b0;
`endif

    hps_ext_master #(
        .STROBE_GAP (SG),
        .CLOSE_GAP  (CG),
        .POLL_PERIOD(PP)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .EXT_BUS  (bus),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd  (req_cmd),
        .req_len  (req_len),
        .wr_we    (wr_we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .done_ack (done_ack)
`ifdef HPS_EXT_MASTER_POLL_EN
        ,
        .poll_done(poll_done)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic              ack;
        int                strobes;
        int                en;
        bit                poll;
        int                n;
        logic [15:0][15:0] rd;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] word_q[$];
    logic [15:0] wm [16];
    int          checks = 0;
    int          errors = 0;
    int          pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder: answers each strobed word with word ^ 0x0015, or 0 when NACKing.
    always @(posedge clk_sys) begin
        rst_at_edge <= reset;
        if (io_strobe === 1'b1) begin
            rsp_q <= resp_ack ? (io_din ^ 16'h0015) : 16'h0000;
        end
    end

    int   s_cnt = 0, e_cnt = 0, c_cnt = 0, sw_idx = 0, sw_n = 0;
    bit   sw_on = 0;
    rec_t cur;

    always @(negedge clk_sys) begin
        if (rst_at_edge) begin
            s_cnt = 0; e_cnt = 0; c_cnt = 0; sw_on = 0;
            chk("rst_io_enable", io_enable, 0);
            chk("rst_io_strobe", io_strobe, 0);
            chk("rst_io_din", io_din, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done | pd, 0);
            chk("rst_done_ack", done_ack, 0);
            chk("rst_req_ready", req_ready, 1);
        end else begin
            if (sw_on) begin
                chk($sformatf("rd[%0d]", sw_idx), rd_data, cur.rd[sw_idx]);
                sw_idx++;
                if (sw_idx == sw_n) begin
                    sw_on = 0;
                    pending--;
                end else begin
                    rd_addr = 4'(sw_idx);
                end
            end
            if (io_strobe) begin
                s_cnt++;
                if (word_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected: din %0h, expected no strobe", io_din);
                end else begin
                    chk("strobe_din", io_din, word_q.pop_front());
                end
            end
            if (io_enable) e_cnt++;
            if (busy && !io_enable) c_cnt++;
            if (done || pd) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: done=%0b poll_done=%0b, expected none", done, pd);
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_kind_poll", pd, cur.poll);
                    chk("done_ack", done_ack, cur.ack);
                    chk("strobe_count", s_cnt, cur.strobes);
                    chk("enable_cycles", e_cnt, cur.en);
                    chk("close_cycles", c_cnt, CG);
                    chk("busy_at_done", busy, 1);
                    s_cnt = 0; e_cnt = 0; c_cnt = 0;
                    if (cur.n == 0) begin
                        pending--;
                    end else begin
                        sw_on = 1; sw_idx = 0; sw_n = cur.n; rd_addr = 4'd0;
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] cmd, input int len, input logic ack, input bit poll);
        rec_t r;
        int   n;
        n = (len > 16) ? 16 : len;
        r.ack = ack; r.strobes = n + 1; r.en = 1 + (n + 1) * (1 + SG);
        r.poll = poll; r.n = n; r.rd = '0;
        word_q.push_back(cmd);
        for (int i = 0; i < n; i++) begin
            word_q.push_back(wm[i]);
            r.rd[i] = ack ? (wm[i] ^ 16'h0015) : 16'h0000;
        end
        exp_q.push_back(r);
        pending++;
    endtask

    task automatic issue(input logic [15:0] cmd, input int len, input logic ack);
        resp_ack = ack;
        push_exp(cmd, len, ack, 1'b0);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_cmd = cmd; req_len = 5'(len);
        @(negedge clk_sys);
        req_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_we = 1'b1; wr_addr = 4'(a); wr_data = d; wm[a] = d;
        @(negedge clk_sys);
        wr_we = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((pending != 0 || busy) && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL timeout: pending=%0d busy=%0b, expected 0 and 0", pending, busy);
            word_q.delete(); exp_q.delete(); pending = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        word_q.delete(); exp_q.delete(); pending = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, sc, idle;
        for (int i = 0; i < 16; i++) wm[i] = 16'h0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) wr(i, 16'($urandom));

        wr(0, 16'h0000); issue(16'h00F1, 1, 1'b1); wait_idle();
        wr(0, 16'h0001); issue(16'h00F3, 1, 1'b1); wait_idle();
        issue(16'h1234, 1, 1'b0); wait_idle();
        issue(16'hABCD, 20, 1'b1); wait_idle();
        issue(16'h5555, 0, 1'b1); wait_idle();
        issue(16'h0F0F, 16, 1'b0); wait_idle();

        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) wr($urandom_range(0, 15), 16'($urandom));
            issue(16'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        // Reset in the first GAP cycle after the second strobe of a len-7 transfer.
        issue(16'h0777, 7, 1'b1);
        sc = 0;
        for (int t = 0; t < 100 && sc < 2; t++) begin
            if (io_strobe) sc++;
            if (sc < 2) @(negedge clk_sys);
        end
        chk("mid_reset_strobes_seen", sc, 2);
        @(negedge clk_sys);
        do_reset();
        issue(16'h00F1, 3, 1'b1); wait_idle();

`ifdef HPS_EXT_MASTER_POLL_EN
        resp_ack = 1'b1;
        do_reset();
        push_exp(16'h00F0, 7, 1'b1, 1'b1);
        idle = 0;
        while (!busy && idle < 200) begin
            idle++;
            @(negedge clk_sys);
        end
        chk("poll_idle_cycles", idle, PP);
        wait_idle();
        do_reset();
        repeat (PP - 1) @(negedge clk_sys);
        issue(16'h0ABC, 2, 1'b1);
        wait_idle();
`else
        idle = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
